// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: hazard stall/flush control with MDU occupancy FSM; define MDU_DIV_EN to give divides DIV_CYCLES
module pipeline_stall_ctrl #(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32,
   parameter int CNT_W      = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       RsD,
   input  logic [4:0]       RtD,
   input  logic [4:0]       WriteRegE,
   input  logic [4:0]       WriteRegM,
   input  logic             RegWriteE,
   input  logic             MemtoRegE,
   input  logic             MemtoRegM,
   input  logic             BranchD,
   input  logic             JumpRegD,
   input  logic             PCSrcD,
   input  logic             MdStartE,
   input  logic             MdDivE,
   input  logic             MdUseD,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic             MdBusy,
   output logic             MdDone,
   output logic [CNT_W-1:0] MdCount
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} mdState_t;
   mdState_t state, nextState;
   logic [CNT_W-1:0] count, nextCount, loadVal;
   logic eRs, eRt, mRs, mRt, lwStall, brStall, mdStall, stall;
   assign eRs = RegWriteE && WriteRegE != 5'd0 && WriteRegE == RsD;
   assign eRt = RegWriteE && WriteRegE != 5'd0 && WriteRegE == RtD;
   assign mRs = MemtoRegM && WriteRegM != 5'd0 && WriteRegM == RsD;
   assign mRt = MemtoRegM && WriteRegM != 5'd0 && WriteRegM == RtD;
   assign lwStall = MemtoRegE && WriteRegE != 5'd0 && (WriteRegE == RsD || WriteRegE == RtD);
   assign brStall = ((BranchD || JumpRegD) && (eRs || mRs)) || (BranchD && (eRt || mRt));
   assign mdStall = MdUseD && (MdStartE || state != IDLE);
   assign stall   = lwStall || brStall || mdStall;
   assign StallF  = stall && !rst;
   assign StallD  = stall && !rst;
   assign FlushE  = stall && !rst;
   assign FlushD  = PCSrcD && !stall && !rst;
`ifdef MDU_DIV_EN
   assign loadVal = MdDivE ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
`else
   logic unusedDiv;
   assign unusedDiv = MdDivE | (DIV_CYCLES == 0);
   assign loadVal   = CNT_W'(MUL_CYCLES - 1);
`endif
   // MDU occupancy: load on start, count down while busy, one DONE cycle for the HI/LO write
   always_comb begin
      nextState = state;
      nextCount = count;
      unique case (state)
         IDLE: begin
            nextState = MdStartE ? BUSY : IDLE;
            nextCount = MdStartE ? loadVal : '0;
         end
         BUSY: begin
            nextState = (count == '0) ? DONE : BUSY;
            nextCount = (count == '0) ? '0 : count - CNT_W'(1);
         end
         DONE: begin
            nextState = MdStartE ? BUSY : IDLE;
            nextCount = MdStartE ? loadVal : '0;
         end
         default: begin
            nextState = IDLE;
            nextCount = '0;
         end
      endcase
   end
   // state register; reset abandons any in-flight operation without a DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= nextState;
         count <= nextCount;
      end
   end
   assign MdBusy  = state == BUSY;
   assign MdDone  = state == DONE;
   assign MdCount = count;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: scoreboard bench for hazard controls and MDU timing
module tb_pipeline_stall_ctrl;
   logic clk = 1'b0;
   logic rst;
   logic [4:0] RsD, RtD, WriteRegE, WriteRegM;
   logic RegWriteE, MemtoRegE, MemtoRegM, BranchD, JumpRegD, PCSrcD, MdStartE, MdDivE, MdUseD;
   logic StallF, StallD, FlushD, FlushE, MdBusy, MdDone;
   logic [5:0] MdCount;
   typedef struct {
      bit stall;
      bit flushD;
      bit busy;
      bit done;
      int count;
   } exp_t;
   exp_t sb[$];
   bit mdActive;
   int mdSince, mdNum;
   int checks = 0, failures = 0;
   pipeline_stall_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .RsD(RsD), .RtD(RtD), .WriteRegE(WriteRegE), .WriteRegM(WriteRegM),
      .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
      .JumpRegD(JumpRegD), .PCSrcD(PCSrcD), .MdStartE(MdStartE), .MdDivE(MdDivE), .MdUseD(MdUseD),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .MdBusy(MdBusy), .MdDone(MdDone), .MdCount(MdCount)
   );
   always #5 clk = ~clk;
   task automatic checkVal(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask
   function automatic int cycLen(input bit d);
`ifdef MDU_DIV_EN
      return d ? 32 : 4;
`else
      return 4;
`endif
   endfunction
   task automatic clearIn();
      {RsD, RtD, WriteRegE, WriteRegM} = '0;
      {RegWriteE, MemtoRegE, MemtoRegM, BranchD, JumpRegD, PCSrcD, MdStartE, MdDivE, MdUseD} = '0;
   endtask
   task automatic cycle();
      exp_t e;
      bit ldS, brS, mdS, st;
      if (rst) mdActive = 0;
      ldS = MemtoRegE && WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD);
      brS = (BranchD && ((RegWriteE && WriteRegE != 0 && (WriteRegE == RsD || WriteRegE == RtD)) ||
                         (MemtoRegM && WriteRegM != 0 && (WriteRegM == RsD || WriteRegM == RtD)))) ||
            (JumpRegD && ((RegWriteE && WriteRegE != 0 && WriteRegE == RsD) ||
                          (MemtoRegM && WriteRegM != 0 && WriteRegM == RsD)));
      mdS = MdUseD && (MdStartE || mdActive);
      st = !rst && (ldS || brS || mdS);
      e.stall  = st;
      e.flushD = !rst && PCSrcD && !st;
      e.busy   = mdActive && mdSince <= mdNum;
      e.done   = mdActive && mdSince == mdNum + 1;
      e.count  = e.busy ? mdNum - mdSince : 0;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      checkVal("StallF", StallF, e.stall);
      checkVal("StallD", StallD, e.stall);
      checkVal("FlushE", FlushE, e.stall);
      checkVal("FlushD", FlushD, e.flushD);
      checkVal("MdBusy", MdBusy, e.busy);
      checkVal("MdDone", MdDone, e.done);
      checkVal("MdCount", MdCount, e.count);
      @(posedge clk);
      if (rst) mdActive = 0;
      else if (MdStartE && (!mdActive || mdSince == mdNum + 1)) begin
         mdActive = 1;
         mdSince  = 1;
         mdNum    = cycLen(MdDivE);
      end else if (mdActive) begin
         mdSince++;
         if (mdSince == mdNum + 2) mdActive = 0;
      end
      #1;
   endtask
   initial begin
      clearIn();
      rst = 1'b1;
      mdActive = 0;
      @(posedge clk);
      #1;
      PCSrcD = 1; MdUseD = 1; MdStartE = 1;
      cycle();
      rst = 1'b0;
      clearIn();
      cycle();
      MemtoRegE = 1; WriteRegE = 5; RsD = 5;
      cycle();
      WriteRegE = 0; RsD = 0; RtD = 0;
      cycle();
      clearIn();
      BranchD = 1; RegWriteE = 1; WriteRegE = 8; RtD = 8; PCSrcD = 1;
      cycle();
      RegWriteE = 0;
      cycle();
      clearIn();
      JumpRegD = 1; RegWriteE = 1; WriteRegE = 9; RtD = 9; RsD = 3;
      cycle();
      RsD = 9;
      cycle();
      clearIn();
      BranchD = 1; MemtoRegM = 1; WriteRegM = 7; RtD = 7;
      cycle();
      WriteRegM = 0; RtD = 0;
      cycle();
      for (int i = 0; i < 60; i++) begin
         RsD = 5'($urandom_range(0, 3)); RtD = 5'($urandom_range(0, 3));
         WriteRegE = 5'($urandom_range(0, 3)); WriteRegM = 5'($urandom_range(0, 3));
         {RegWriteE, MemtoRegE, MemtoRegM, BranchD, JumpRegD, PCSrcD, MdUseD} = 7'($urandom);
         MdStartE = 1'($urandom) && (!mdActive || mdSince == mdNum + 1);
         cycle();
      end
      clearIn();
      repeat (8) cycle();
      MdUseD = 1; MdStartE = 1;
      cycle();
      MdStartE = 0;
      repeat (7) cycle();
      MdStartE = 1;
      cycle();
      MdStartE = 0;
      repeat (4) cycle();
      MdStartE = 1;
      cycle();
      MdStartE = 0;
      repeat (6) cycle();
      MdStartE = 1; MdDivE = 1;
      cycle();
      MdStartE = 0; MdDivE = 0;
      repeat (38) cycle();
      MdStartE = 1; MdDivE = 1;
      cycle();
      MdStartE = 0; MdDivE = 0;
      repeat (9) cycle();
      rst = 1'b1; PCSrcD = 1;
      cycle();
      rst = 1'b0; PCSrcD = 0; MdUseD = 0;
      repeat (40) cycle();
      MdUseD = 1; MdStartE = 1;
      cycle();
      MdStartE = 0;
      repeat (7) cycle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
